freq_gate_ctrl: RTL and testbench

Gate-time sequencer and edge counter for frequency measurement. It synchronises an asynchronous measured signal into the system clock domain and generates a gate window of programmable length in clock cycles. It counts rising edges of the measured signal inside that window, then presents the count through a valid/ready result port. It sits between the register/host interface, which supplies gate length and start and consumes results, and the external measured-signal pin, which arrives on `sig_in`.

---
 rtl/freq_gate_ctrl.sv | 131 +++++++++++++
 tb/tb_freq_gate_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - gate-time sequencer and rising-edge counter for frequency measurement
// Define FREQ_GATE_AUTO_EN for auto re-arm mode with sticky overrun tracking.
module freq_gate_ctrl #(
  parameter int CNT_W  = 40,
  parameter int GATE_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              sig_in,
  output logic              gate,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overflow,
  output logic              overrun
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_HOLD} state_t;

  state_t            state, state_nx;
  logic              s1, s2, s3;
  logic [GATE_W-1:0] len_q, timer;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              ovf_acc, ovf_nx;
  logic              edge_pulse, start_ok, handshake, win_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_pulse = s2 & ~s3;
  assign start_ok   = start & (gate_len != '0);
  assign handshake  = result_valid & result_ready;
  assign win_done   = (state == S_GATE) && (timer == GATE_W'(1));
  assign gate       = (state == S_GATE);
  assign busy       = (state != S_IDLE);

  // Saturating count including the pulse of the current gate cycle.
  always_comb begin
    cnt_nx = cnt;
    ovf_nx = ovf_acc;
    if (gate && edge_pulse) begin
      if (&cnt) ovf_nx = 1'b1;
      else      cnt_nx = cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start_ok) state_nx = S_ARM;
      S_ARM:  state_nx = S_GATE;
      S_GATE: if (win_done) state_nx = S_HOLD;
      S_HOLD: begin
`ifdef FREQ_GATE_AUTO_EN
        state_nx = start_ok ? S_ARM : S_IDLE;
`else
        if (handshake) state_nx = S_IDLE;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      len_q   <= '0;
      timer   <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx == S_ARM) len_q <= gate_len;
      case (state)
        S_ARM: begin
          cnt     <= '0;
          ovf_acc <= 1'b0;
          timer   <= len_q;
        end
        S_GATE: begin
          cnt     <= cnt_nx;
          ovf_acc <= ovf_nx;
          timer   <= timer - GATE_W'(1);
        end
        default: ;
      endcase
    end
  end

  // A write coinciding with a handshake hands over the old value and keeps valid set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else if (win_done) begin
      result       <= cnt_nx;
      overflow     <= ovf_nx;
      result_valid <= 1'b1;
    end else if (handshake) begin
      result_valid <= 1'b0;
    end
  end

`ifdef FREQ_GATE_AUTO_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         overrun_q <= 1'b0;
    else if (handshake)                 overrun_q <= 1'b0;
    else if (win_done && result_valid)  overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// tb/tb_freq_gate_ctrl.sv - randomized self-checking bench for freq_gate_ctrl
module tb_freq_gate_ctrl;
  localparam int CNT_W   = 4;
  localparam int GATE_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [GATE_W-1:0] gate_len = '0;
  logic              sig_in = 1'b0;
  logic              result_ready = 1'b0;
  logic              gate, busy, result_valid, overflow, overrun;
  logic [CNT_W-1:0]  result;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int rises[$];
  bit sig_run = 1'b0;
  bit sig_fixed = 1'b0;
  int ph = 0;
  int half = 5;

  freq_gate_ctrl #(.CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_len(gate_len), .sig_in(sig_in),
    .gate(gate), .busy(busy), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .overflow(overflow), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Measured signal: changes 2 time units after the falling edge, phases >= 2 cycles.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sig_run) begin
        if (ph == 0) begin
          sig_in = ~sig_in;
          if (sig_in) rises.push_back(cyc);
          ph = sig_fixed ? half - 1 : int'($urandom_range(1, 4));
        end else begin
          ph--;
        end
      end
    end
  end

  // Reference: a rise changing in cycle c yields a pulse in cycle c+2; count pulses in gate cycles.
  function automatic logic [CNT_W:0] expect_window(int gs, int len);
    int n = 0;
    foreach (rises[i]) if (rises[i] + 2 >= gs && rises[i] + 2 < gs + len) n++;
    if (n > CNT_MAX) return {1'b1, CNT_W'(CNT_MAX)};
    return {1'b0, CNT_W'(n)};
  endfunction

  task automatic stop_sig();
    @(negedge clk);
    sig_run = 1'b0;
    sig_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic start_rand_sig();
    sig_fixed = 1'b0;
    ph = 0;
    sig_run = 1'b1;
  endtask

  task automatic run_window(input int len, input bit sync);
    int t0, g0, gcnt, lim;
    logic [CNT_W:0] ex;
    @(negedge clk);
    rises.delete();
    if (sync) begin
      sig_fixed = 1'b1;
      half = 5;
      ph = 0;
      sig_run = 1'b1;
    end
    gate_len = GATE_W'(len);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    g0 = -1;
    gcnt = 0;
    lim = len + 10;
    while (result_valid !== 1'b1 && lim > 0) begin
      if (gate === 1'b1) begin
        if (g0 < 0) g0 = cyc;
        gcnt++;
      end
      @(negedge clk);
      lim--;
    end
    n_checks++;
    if (result_valid !== 1'b1) $display("FAIL window_timeout: result_valid=%b required 1 (L=%0d)", result_valid, len);
    else n_pass++;
    n_checks++;
    if (g0 !== t0 + 2) $display("FAIL gate_start: first gate cycle %0d required %0d", g0, t0 + 2);
    else n_pass++;
    n_checks++;
    if (gcnt !== len) $display("FAIL gate_length: %0d gate cycles required %0d", gcnt, len);
    else n_pass++;
    n_checks++;
    if (cyc !== t0 + 2 + len) $display("FAIL valid_time: valid at cycle %0d required %0d", cyc, t0 + 2 + len);
    else n_pass++;
    ex = expect_window(t0 + 2, len);
    n_checks++;
    if (result !== ex[CNT_W-1:0]) $display("FAIL result: got %0d required %0d (L=%0d)", result, ex[CNT_W-1:0], len);
    else n_pass++;
    n_checks++;
    if (overflow !== ex[CNT_W]) $display("FAIL overflow: got %b required %b (L=%0d)", overflow, ex[CNT_W], len);
    else n_pass++;
  endtask

  task automatic accept();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    n_checks++;
    if (result_valid !== 1'b0) $display("FAIL accept_clear: result_valid=%b required 0", result_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (gate !== 1'b0) $display("FAIL reset_gate: got %b required 0", gate); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    n_checks++; if (result !== '0) $display("FAIL reset_result: got %0d required 0", result); else n_pass++;
    n_checks++; if (result_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", result_valid); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", overflow); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b required 0", overrun); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    stop_sig();
    result_ready = 1'b1;
    run_window(100, 1'b1);
    n_checks++;
    if (result !== CNT_W'(10)) $display("FAIL basic_count: got %0d required 10", result);
    else n_pass++;
    @(negedge clk);
    result_ready = 1'b0;
    n_checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_single_valid: valid=%b busy=%b required 0 0", result_valid, busy);
    else n_pass++;
  endtask

  task automatic test_saturate();
    stop_sig();
    run_window(200, 1'b1);
    n_checks++;
    if (result !== CNT_W'(15) || overflow !== 1'b1) $display("FAIL saturate: result=%0d overflow=%b required 15 1", result, overflow);
    else n_pass++;
    accept();
  endtask

  task automatic test_reset_mid();
    int gcnt = 0;
    int lim = 200;
    start_rand_sig();
    @(negedge clk);
    gate_len = GATE_W'(100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (gcnt < 40 && lim > 0) begin
      @(negedge clk);
      lim--;
      if (gate === 1'b1) gcnt++;
    end
    n_checks++;
    if (gcnt !== 40) $display("FAIL reset_mid_reach: %0d gate cycles required 40", gcnt);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (gate !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0)
      $display("FAIL reset_mid_ctrl: gate=%b busy=%b valid=%b required 0 0 0", gate, busy, result_valid);
    else n_pass++;
    n_checks++;
    if (result !== '0 || overflow !== 1'b0) $display("FAIL reset_mid_result: result=%0d overflow=%b required 0 0", result, overflow);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    run_window(20, 1'b0);
    accept();
  endtask

  task automatic test_zero_len();
    int bad = 0;
    @(negedge clk);
    gate_len = '0;
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || gate !== 1'b0 || result_valid !== 1'b0) bad++;
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b0 || result_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL zero_len: %0d bad cycles required 0", bad);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] held;
    int bad = 0;
    start_rand_sig();
    result_ready = 1'b0;
    run_window(30, 1'b0);
    held = result;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 20) begin
        gate_len = GATE_W'(10);
        start = 1'b1;
      end
      if (i == 21) start = 1'b0;
      if (result !== held || gate !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b1 || overrun !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL backpressure_hold: %0d bad cycles required 0", bad);
    else n_pass++;
    accept();
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || gate !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL backpressure_idle: %0d bad cycles required 0", bad);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [CNT_W-1:0] held;
    int len, d, bad;
    start_rand_sig();
    result_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      len = (i == 0) ? 1 : int'($urandom_range(2, 60));
      d = int'($urandom_range(0, 4));
      run_window(len, 1'b0);
      held = result;
      bad = 0;
      repeat (d) begin
        @(negedge clk);
        if (result !== held || result_valid !== 1'b1) bad++;
      end
      n_checks++;
      if (bad !== 0) $display("FAIL random_stable: %0d bad cycles required 0 (iter %0d)", bad, i);
      else n_pass++;
      accept();
    end
  endtask

`ifdef FREQ_GATE_AUTO_EN
  task automatic test_back_to_back();
    int gexp, lim;
    logic [CNT_W:0] ex;
    logic exp_ov;
    start_rand_sig();
    result_ready = 1'b0;
    @(negedge clk);
    rises.delete();
    gate_len = GATE_W'(50);
    start = 1'b1;
    gexp = cyc + 2;
    for (int w = 0; w < 3; w++) begin
      lim = 10;
      while (gate !== 1'b1 && lim > 0) begin
        @(negedge clk);
        lim--;
      end
      n_checks++;
      if (cyc !== gexp) $display("FAIL b2b_gate_start: window %0d at cycle %0d required %0d", w, cyc, gexp);
      else n_pass++;
      if (w == 2) begin
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        n_checks++;
        if (overrun !== 1'b0 || result_valid !== 1'b0)
          $display("FAIL b2b_overrun_clear: overrun=%b valid=%b required 0 0", overrun, result_valid);
        else n_pass++;
      end
      while (cyc < gexp + 50) @(negedge clk);
      ex = expect_window(gexp, 50);
      exp_ov = (w == 1);
      n_checks++;
      if (gate !== 1'b0 || result_valid !== 1'b1) $display("FAIL b2b_hold: gate=%b valid=%b required 0 1", gate, result_valid);
      else n_pass++;
      n_checks++;
      if (result !== ex[CNT_W-1:0]) $display("FAIL b2b_result: got %0d required %0d (window %0d)", result, ex[CNT_W-1:0], w);
      else n_pass++;
      n_checks++;
      if (overrun !== exp_ov) $display("FAIL b2b_overrun: got %b required %b (window %0d)", overrun, exp_ov, w);
      else n_pass++;
      gexp += 52;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_idle: busy=%b required 0", busy);
    else n_pass++;
    accept();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_reset_mid();
    test_zero_len();
`ifdef FREQ_GATE_AUTO_EN
    test_back_to_back();
`else
    test_backpressure();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
